// File: rtl/bwt_pkg.sv
// Shared definitions for the rank-counting BWT core: FSM states, default sizes,
// and the modulo-add helper used for wrapping rotation indices.
package bwt_pkg;

   localparam int CHAR_W_DEF  = 8;
   localparam int MAX_LEN_DEF = 1024;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMP   = 3'd1,
      NEXT  = 3'd2,
      STORE = 3'd3,
      DONE  = 3'd4
   } state_t;

   // (x + y) mod n for x, y < n, using a conditional subtract instead of a divider
   function automatic logic [31:0] mod_add(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] n);
      logic [31:0] sum;
      sum = x + y;
      if (sum >= n) begin
         return sum - n;
      end else begin
         return sum;
      end
   endfunction

endpackage

// File: rtl/bwt_char_ram.sv
// Character register array with one synchronous write port and two
// asynchronous read ports; contents are intentionally not reset.
module bwt_char_ram #(
   parameter int W     = 8,
   parameter int DEPTH = 1024,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [W-1:0]  rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [W-1:0]  rdata_b
);

   logic [W-1:0] mem [DEPTH];

   // Write port; addresses past DEPTH are dropped for non-power-of-two depths
   always_ff @(posedge clk) begin
      if (we && (32'(waddr) < DEPTH)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/bwt_rank_core.sv
// Forward BWT by rank counting over an internal string buffer.
// Optional cycle_cnt output is enabled with `define BWT_CYCLE_CNT_EN.
module bwt_rank_core
   import bwt_pkg::*;
#(
   parameter int CHAR_W  = CHAR_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   localparam int ADDR_W = $clog2(MAX_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [CHAR_W-1:0] wr_data,
   input  logic [ADDR_W:0]   length,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] primary_idx,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [CHAR_W-1:0] rd_data
`ifdef BWT_CYCLE_CNT_EN
   ,
   output logic [31:0]       cycle_cnt
`endif
);

   state_t            state;
   logic [ADDR_W:0]   n;
   logic [ADDR_W:0]   n_m1;
   logic [ADDR_W-1:0] i, j, k, rank;
   logic [ADDR_W-1:0] a_addr, b_addr;
   logic [CHAR_W-1:0] a, b, out_rdata;
   logic              in_we, out_we, len_ok;

   assign n_m1   = n - (ADDR_W+1)'(1);
   assign len_ok = (length != (ADDR_W+1)'(0)) && (length <= (ADDR_W+1)'(MAX_LEN));

   // Read-address and write-enable steering; port a doubles as the STORE source
   always_comb begin
      in_we  = wr_en && (state == IDLE);
      out_we = (state == STORE);
      b_addr = ADDR_W'(mod_add(32'(j), 32'(k), 32'(n)));
      if (state == STORE) begin
         a_addr = ADDR_W'(mod_add(32'(i), 32'(n_m1), 32'(n)));
      end else begin
         a_addr = ADDR_W'(mod_add(32'(i), 32'(k), 32'(n)));
      end
   end

   bwt_char_ram #(.W(CHAR_W), .DEPTH(MAX_LEN)) u_in_buf (
      .clk     (clk),
      .we      (in_we),
      .waddr   (wr_addr),
      .wdata   (wr_data),
      .raddr_a (a_addr),
      .rdata_a (a),
      .raddr_b (b_addr),
      .rdata_b (b)
   );

   bwt_char_ram #(.W(CHAR_W), .DEPTH(MAX_LEN)) u_out_buf (
      .clk     (clk),
      .we      (out_we),
      .waddr   (rank),
      .wdata   (a),
      .raddr_a (rd_addr),
      .rdata_a (out_rdata),
      .raddr_b (rd_addr),
      .rdata_b ()
   );

   // Transform sequencer with registered status outputs and read data
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         n           <= '0;
         i           <= '0;
         j           <= '0;
         k           <= '0;
         rank        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         primary_idx <= '0;
         rd_data     <= '0;
      end else begin
         rd_data <= out_rdata;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     n     <= length;
                     i     <= '0;
                     j     <= '0;
                     k     <= '0;
                     rank  <= '0;
                     done  <= 1'b0;
                     busy  <= 1'b1;
                     state <= CMP;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            CMP: begin
               if (j == i) begin
                  state <= NEXT;
               end else if (b < a) begin
                  rank  <= rank + ADDR_W'(1);
                  state <= NEXT;
               end else if (b > a) begin
                  state <= NEXT;
               end else if ({1'b0, k} < n_m1) begin
                  k <= k + ADDR_W'(1);
               end else begin
                  // full tie: earlier rotation index wins the lower rank
                  if (j < i) begin
                     rank <= rank + ADDR_W'(1);
                  end
                  state <= NEXT;
               end
            end
            NEXT: begin
               k <= '0;
               if ({1'b0, j} < n_m1) begin
                  j     <= j + ADDR_W'(1);
                  state <= CMP;
               end else begin
                  state <= STORE;
               end
            end
            STORE: begin
               if (i == '0) begin
                  primary_idx <= rank;
               end
               if ({1'b0, i} < n_m1) begin
                  i     <= i + ADDR_W'(1);
                  j     <= '0;
                  rank  <= '0;
                  state <= CMP;
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef BWT_CYCLE_CNT_EN
   // Busy-cycle counter: cleared on an accepted start, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
      end else if ((state == IDLE) && start && len_ok) begin
         cycle_cnt <= '0;
      end else if (busy && (cycle_cnt != 32'hFFFF_FFFF)) begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end else begin
         cycle_cnt <= cycle_cnt;
      end
   end
`endif

endmodule
